// File: rtl/fibonacci_gen.sv
// Iterative second-order additive sequence generator (Fibonacci, Lucas or custom seeds).
// One adder, start/ready/done_tick handshake, abort, and selectable overflow policy.
module fibonacci_gen #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 6,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] s0,
    input  logic [DATA_W-1:0] s1,
    input  logic [IDX_W-1:0]  i,
    output logic              ready,
    output logic              done_tick,
    output logic [DATA_W-1:0] f,
    output logic              ovf
);

    typedef enum logic [1:0] {StIdle, StOp, StDone} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] t0_q, t0_d, t1_q, t1_d;
    logic [DATA_W-1:0] res_q, res_d, f_q, f_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic              run_ovf_q, run_ovf_d;
    logic              ovf_q, ovf_d;
    logic              settled_q, settled_d;
    logic [DATA_W-1:0] seed0, seed1;
    logic [DATA_W:0]   sum;

    always_comb begin
        case (mode)
            2'd1: begin
                seed0 = DATA_W'(2);
                seed1 = DATA_W'(1);
            end
            2'd2: begin
                seed0 = s0;
                seed1 = s1;
            end
            default: begin
                seed0 = '0;
                seed1 = DATA_W'(1);
            end
        endcase
    end

    assign sum = {1'b0, t0_q} + {1'b0, t1_q};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the first OP cycle is a settle bubble before the index test
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StOp;
            StOp: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settled_q && (n_q == '0 || n_q == IDX_W'(1))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        ready     = (state_q == StIdle);
        done_tick = (state_q == StDone);
        f         = f_q;
        ovf       = ovf_q;
    end

    always_comb begin
        t0_d      = t0_q;
        t1_d      = t1_q;
        n_d       = n_q;
        res_d     = res_q;
        run_ovf_d = run_ovf_q;
        settled_d = settled_q;
        f_d       = f_q;
        ovf_d     = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    t0_d      = seed0;
                    t1_d      = seed1;
                    n_d       = i;
                    run_ovf_d = 1'b0;
                    settled_d = 1'b0;
                end
            end
            StOp: begin
                if (!abort) begin
                    if (!settled_q) begin
                        settled_d = 1'b1;
                    end else if (n_q == '0) begin
                        res_d = t0_q;
                    end else if (n_q == IDX_W'(1)) begin
                        res_d = t1_q;
                    end else begin
                        // Saturation is absorbing: an all-ones t1 keeps carrying
                        if (sum[DATA_W]) begin
                            run_ovf_d = 1'b1;
                            t1_d      = SATURATE ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
                        end else begin
                            t1_d = sum[DATA_W-1:0];
                        end
                        t0_d = t1_q;
                        n_d  = n_q - IDX_W'(1);
                    end
                end
            end
            StDone: begin
                f_d   = res_q;
                ovf_d = run_ovf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t0_q      <= '0;
            t1_q      <= '0;
            n_q       <= '0;
            res_q     <= '0;
            run_ovf_q <= 1'b0;
            settled_q <= 1'b0;
            f_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            n_q       <= n_d;
            res_q     <= res_d;
            run_ovf_q <= run_ovf_d;
            settled_q <= settled_d;
            f_q       <= f_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fibonacci_gen.sv
// Bench for fibonacci_gen: saturating and wrapping instances share stimulus and are
// checked against an arithmetic sequence model and the documented completion latency.
module tb_fibonacci_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [5:0]  i;
    logic        ready_s, done_s, ovf_s;
    logic        ready_w, done_w, ovf_w;
    logic [31:0] f_s, f_w;

    int total = 0;
    int bad   = 0;

    fibonacci_gen #(.DATA_W(32), .IDX_W(6), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .s0(s0), .s1(s1),
        .i(i), .ready(ready_s), .done_tick(done_s), .f(f_s), .ovf(ovf_s)
    );

    fibonacci_gen #(.DATA_W(32), .IDX_W(6), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .s0(s0), .s1(s1),
        .i(i), .ready(ready_w), .done_tick(done_w), .f(f_w), .ovf(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // term(idx) from the recurrence with the overflow rule applied after each addition
    function automatic void model(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                                  input int idx, input bit sat,
                                  output logic [31:0] fo, output bit ov);
        longint unsigned a, b, s;
        a  = (m == 2'd2) ? longint'(a0) : (m == 2'd1) ? 64'd2 : 64'd0;
        b  = (m == 2'd2) ? longint'(a1) : 64'd1;
        ov = 1'b0;
        for (int k = 2; k <= idx; k++) begin
            s = a + b;
            if (s > 64'hFFFF_FFFF) begin
                ov = 1'b1;
                s  = sat ? 64'hFFFF_FFFF : (s & 64'hFFFF_FFFF);
            end
            a = b;
            b = s;
        end
        fo = (idx == 0) ? 32'(a) : 32'(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one run, scramble inputs after acceptance, return at the first IDLE cycle after
    // done_tick. lat = c where done_tick was seen in the cycle after edge E(c); -1 on timeout.
    task automatic run(input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1,
                       input int idx, input bit abort_at_start, output int lat, output int ticks);
        mode  = m;
        s0    = a0;
        s1    = a1;
        i     = 6'(idx);
        start = 1'b1;
        abort = abort_at_start;
        step();
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'($urandom);
        s0    = $urandom;
        s1    = $urandom;
        i     = 6'($urandom);
        lat   = -1;
        ticks = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            ticks += int'(done_s) + int'(done_w);
            if (done_s && lat < 0) lat = c;
            if (ready_s && lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        int lat, ticks, late;
        rst = 1'b0;
        #2;
        total++;
        if ({ready_s, done_s, ovf_s, f_s, ready_w, done_w, ovf_w, f_w} !== {3'b100, 32'd0, 3'b100, 32'd0}) begin
            bad++;
            $display("FAIL reset_init: got rdy=%b dt=%b ovf=%b f=%0d, want rdy=1 dt=0 ovf=0 f=0",
                     ready_s, done_s, ovf_s, f_s);
        end
        step();
        rst = 1'b1;
        step();
        run(2'd0, 32'd0, 32'd0, 5, 1'b0, lat, ticks);
        total++;
        if (f_s !== 32'd5) begin
            bad++;
            $display("FAIL reset_prerun: got f=%0d want 5", f_s);
        end
        mode  = 2'd0;
        i     = 6'd40;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #1 rst = 1'b0;
        #1;
        total++;
        if ({ready_s, done_s, ovf_s, f_s, ready_w, done_w, ovf_w, f_w} !== {3'b100, 32'd0, 3'b100, 32'd0}) begin
            bad++;
            $display("FAIL reset_midrun: got rdy=%b dt=%b ovf=%b f=%0d, want rdy=1 dt=0 ovf=0 f=0",
                     ready_s, done_s, ovf_s, f_s);
        end
        #1 rst = 1'b1;
        late = 0;
        repeat (60) begin
            step();
            late += int'(done_s) + int'(done_w) + int'(!ready_s);
        end
        total++;
        if (late !== 0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d done/busy cycles want 0", late);
        end
    endtask

    task automatic test_fib_bounds();
        int idx_t [4] = '{0, 1, 2, 10};
        logic [31:0] exp_t [4] = '{32'd0, 32'd1, 32'd1, 32'd55};
        int lat, ticks;
        for (int k = 0; k < 4; k++) begin
            run(2'd0, 32'd0, 32'd0, idx_t[k], 1'b0, lat, ticks);
            total++;
            if ({f_s, ovf_s, f_w, ovf_w} !== {exp_t[k], 1'b0, exp_t[k], 1'b0}) begin
                bad++;
                $display("FAIL fib_i%0d: got f=%0d/%0d ovf=%b/%b want f=%0d ovf=0", idx_t[k],
                         f_s, f_w, ovf_s, ovf_w, exp_t[k]);
            end
            total++;
            if (lat !== ((idx_t[k] > 1 ? idx_t[k] : 1) + 1) || ticks !== 2) begin
                bad++;
                $display("FAIL fib_timing_i%0d: got lat=%0d ticks=%0d want lat=%0d ticks=2",
                         idx_t[k], lat, ticks, (idx_t[k] > 1 ? idx_t[k] : 1) + 1);
            end
        end
    endtask

    task automatic test_seeds();
        logic [1:0]  m_t [3] = '{2'd1, 2'd2, 2'd3};
        int          idx_t [3] = '{5, 4, 7};
        logic [31:0] exp_t [3] = '{32'd11, 32'd21, 32'd13};
        int lat, ticks;
        for (int k = 0; k < 3; k++) begin
            run(m_t[k], 32'd3, 32'd5, idx_t[k], 1'b0, lat, ticks);
            total++;
            if ({f_s, ovf_s, f_w, ovf_w} !== {exp_t[k], 1'b0, exp_t[k], 1'b0} || ticks !== 2) begin
                bad++;
                $display("FAIL seeds_mode%0d: got f=%0d/%0d ovf=%b/%b ticks=%0d want f=%0d ovf=0 ticks=2",
                         m_t[k], f_s, f_w, ovf_s, ovf_w, ticks, exp_t[k]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat, ticks;
        run(2'd0, 32'd0, 32'd0, 47, 1'b0, lat, ticks);
        total++;
        if ({f_s, ovf_s, f_w, ovf_w} !== {32'd2971215073, 1'b0, 32'd2971215073, 1'b0}) begin
            bad++;
            $display("FAIL ovf_i47: got f=%0d/%0d ovf=%b/%b want f=2971215073 ovf=0",
                     f_s, f_w, ovf_s, ovf_w);
        end
        run(2'd0, 32'd0, 32'd0, 48, 1'b0, lat, ticks);
        total++;
        if ({f_s, ovf_s} !== {32'hFFFF_FFFF, 1'b1}) begin
            bad++;
            $display("FAIL ovf_i48_sat: got f=%h ovf=%b want f=ffffffff ovf=1", f_s, ovf_s);
        end
        total++;
        if ({f_w, ovf_w} !== {32'd512559680, 1'b1}) begin
            bad++;
            $display("FAIL ovf_i48_wrap: got f=%0d ovf=%b want f=512559680 ovf=1", f_w, ovf_w);
        end
        run(2'd0, 32'd0, 32'd0, 3, 1'b0, lat, ticks);
        total++;
        if ({f_s, ovf_s, f_w, ovf_w} !== {32'd2, 1'b0, 32'd2, 1'b0}) begin
            bad++;
            $display("FAIL ovf_clear: got f=%0d/%0d ovf=%b/%b want f=2 ovf=0", f_s, f_w, ovf_s, ovf_w);
        end
    endtask

    task automatic test_abort();
        int lat, ticks, seen;
        run(2'd0, 32'd0, 32'd0, 6, 1'b0, lat, ticks);
        mode  = 2'd0;
        i     = 6'd20;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        seen  = 0;
        total++;
        if (ready_s !== 1'b1 || ready_w !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: got ready=%b/%b want 1", ready_s, ready_w);
        end
        repeat (40) begin
            step();
            seen += int'(done_s) + int'(done_w) + int'(!ready_s);
        end
        total++;
        if (seen !== 0 || f_s !== 32'd8 || f_w !== 32'd8) begin
            bad++;
            $display("FAIL abort_quiet: got busy/done=%0d f=%0d/%0d want 0 and f=8", seen, f_s, f_w);
        end
        // abort held across acceptance kills the run in its first OP cycle
        abort = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b0;
        total++;
        if (ready_s !== 1'b1 || done_s !== 1'b0 || f_s !== 32'd8) begin
            bad++;
            $display("FAIL abort_first_op: got ready=%b dt=%b f=%0d want ready=1 dt=0 f=8",
                     ready_s, done_s, f_s);
        end
        run(2'd0, 32'd0, 32'd0, 4, 1'b1, lat, ticks);
        total++;
        if (f_s !== 32'd3 || lat !== 5 || ticks !== 2) begin
            bad++;
            $display("FAIL start_with_abort: got f=%0d lat=%0d ticks=%0d want f=3 lat=5 ticks=2",
                     f_s, lat, ticks);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ticks, idx;
        logic [1:0]  m;
        logic [31:0] a0, a1, ef_s, ef_w;
        bit eo_s, eo_w;
        for (int k = 0; k < 50; k++) begin
            m   = 2'($urandom_range(0, 3));
            idx = int'($urandom_range(0, 63));
            a0  = k[0] ? $urandom : 32'($urandom_range(0, 1000));
            a1  = k[0] ? $urandom : 32'($urandom_range(0, 1000));
            model(m, a0, a1, idx, 1'b1, ef_s, eo_s);
            model(m, a0, a1, idx, 1'b0, ef_w, eo_w);
            run(m, a0, a1, idx, 1'b0, lat, ticks);
            total++;
            if ({f_s, ovf_s, f_w, ovf_w} !== {ef_s, eo_s, ef_w, eo_w}) begin
                bad++;
                $display("FAIL b2b_%0d m=%0d i=%0d: got f=%h/%h ovf=%b/%b want f=%h/%h ovf=%b/%b",
                         k, m, idx, f_s, f_w, ovf_s, ovf_w, ef_s, ef_w, eo_s, eo_w);
            end
            total++;
            if (lat !== ((idx > 1 ? idx : 1) + 1) || ticks !== 2) begin
                bad++;
                $display("FAIL b2b_timing_%0d: got lat=%0d ticks=%0d want lat=%0d ticks=2",
                         k, lat, ticks, (idx > 1 ? idx : 1) + 1);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 2'd0;
        s0    = '0;
        s1    = '0;
        i     = '0;
        test_reset();
        test_fib_bounds();
        test_seeds();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
